// File: rtl/analog_switch_seq.sv
// analog_switch_seq: break-before-make sequencer for the analog switch bank.
module analog_switch_seq #(
  parameter int BREAK_CYC  = 16,
  parameter int SETTLE_CYC = 100,
  parameter int CNT_W      = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_wr_i,
  input  logic [3:0] pud_sel_i,
  input  logic [2:0] tr_sel_i,
  input  logic [3:0] lp_sel_i,
  output logic [3:0] pud_sel_o,
  output logic [2:0] tr_sel_o,
  output logic [3:0] lp_sel_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ovr_o
);
  typedef enum logic [1:0] {IDLE, BREAK, SETTLE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [10:0] wr_cfg, cur, tgt, pend, eff, sel, sel_n;
  logic pend_v, redo, cnt_z, idle_go, idle_eq, fin, chain, drop, brk_end;
  logic busy, done, ovr, busy_n, done_n, ovr_n;
  assign wr_cfg  = {pud_sel_i, tr_sel_i, lp_sel_i};
  assign cnt_z   = cnt == '0;
  assign idle_go = state == IDLE && cfg_wr_i && wr_cfg != cur;
  assign idle_eq = state == IDLE && cfg_wr_i && wr_cfg == cur;
  assign brk_end = state == BREAK && cnt_z;
  assign fin     = state == SETTLE && cnt_z;
  // A write landing on the final SETTLE cycle counts as pending and wins over the stored one
  assign eff     = cfg_wr_i ? wr_cfg : pend;
  assign chain   = fin && (cfg_wr_i || pend_v) && eff != tgt;
  assign drop    = fin && (cfg_wr_i || pend_v) && eff == tgt;
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE  ? (idle_go ? BREAK : IDLE) :
          state == BREAK ? (cnt_z ? SETTLE : BREAK) :
          (cnt_z ? (chain ? BREAK : IDLE) : SETTLE);
  end
  always_comb begin
    sel_n  = (idle_go || chain) ? '0 : brk_end ? tgt : sel;
    busy_n = nxt != IDLE;
    done_n = idle_eq || fin || redo;
    ovr_n  = state != IDLE && cfg_wr_i && pend_v;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      cnt    <= '0;
      cur    <= '0;
      tgt    <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      redo   <= 1'b0;
      sel    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      cnt    <= (idle_go || chain) ? CNT_W'(BREAK_CYC - 1) :
                brk_end ? CNT_W'(SETTLE_CYC - 1) :
                (state != IDLE && !cnt_z) ? cnt - CNT_W'(1) : cnt;
      tgt    <= idle_go ? wr_cfg : chain ? eff : tgt;
      cur    <= fin ? tgt : cur;
      pend_v <= fin ? 1'b0 : (state != IDLE && cfg_wr_i) ? 1'b1 : pend_v;
      pend   <= (state != IDLE && cfg_wr_i) ? wr_cfg : pend;
      redo   <= drop;
      sel    <= sel_n;
      busy   <= busy_n;
      done   <= done_n;
      ovr    <= ovr_n;
    end
  assign {pud_sel_o, tr_sel_o, lp_sel_o} = sel;
  assign busy_o = busy;
  assign done_o = done;
  assign ovr_o  = ovr;
endmodule

// File: tb/tb_analog_switch_seq.sv
// tb_analog_switch_seq: table-driven scoreboard bench with BREAK_CYC=4, SETTLE_CYC=8.
module tb_analog_switch_seq;
  logic clk = 1'b0, rst = 1'b0, cfg_wr = 1'b0;
  logic [10:0] cfg = '0;
  logic [3:0] pud_o, lp_o;
  logic [2:0] tr_o;
  logic busy_o, done_o, ovr_o;
  int checks = 0, failures = 0;
  typedef struct {int cyc; logic rst; logic wr; logic [10:0] cfg;} stim_t;
  typedef struct {int cyc; logic [3:0] m; logic [10:0] sel; logic busy, done, ovr; string name;} exp_t;
  stim_t stim_q[$];
  exp_t exp_q[$];
  localparam logic [10:0] A  = {4'hF, 3'h5, 4'hA};
  localparam logic [10:0] B  = {4'h1, 3'h0, 4'h3};
  localparam logic [10:0] C  = {4'h6, 3'h2, 4'h9};
  localparam logic [10:0] Z  = 11'h0;
  analog_switch_seq #(.BREAK_CYC(4), .SETTLE_CYC(8), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_wr_i(cfg_wr),
    .pud_sel_i(cfg[10:7]), .tr_sel_i(cfg[6:4]), .lp_sel_i(cfg[3:0]),
    .pud_sel_o(pud_o), .tr_sel_o(tr_o), .lp_sel_o(lp_o),
    .busy_o(busy_o), .done_o(done_o), .ovr_o(ovr_o)
  );
  always #5 clk = ~clk;
  task automatic wr(input int c, input logic [10:0] v);
    stim_q.push_back('{c, 1'b0, 1'b1, v});
  endtask
  task automatic rs(input int c);
    stim_q.push_back('{c, 1'b1, 1'b0, Z});
  endtask
  task automatic ex(input int c, input logic [3:0] m, input logic [10:0] s, input logic b, input logic d, input logic o, input string n);
    exp_q.push_back('{c, m, s, b, d, o, n});
  endtask
  task automatic chk(input exp_t e);
    logic [10:0] s;
    logic bad;
    s = {pud_o, tr_o, lp_o};
    bad = (e.m[3] && s !== e.sel) || (e.m[2] && busy_o !== e.busy) ||
          (e.m[1] && done_o !== e.done) || (e.m[0] && ovr_o !== e.ovr);
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s cyc=%0d got sel=%h busy=%b done=%b ovr=%b want sel=%h busy=%b done=%b ovr=%b mask=%b",
               e.name, e.cyc, s, busy_o, done_o, ovr_o, e.sel, e.busy, e.done, e.ovr, e.m);
    end
  endtask
  task automatic run(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      rst = 1'b0; cfg_wr = 1'b0; cfg = '0;
      foreach (stim_q[i]) if (stim_q[i].cyc == c) begin
        rst = stim_q[i].rst; cfg_wr = stim_q[i].wr; cfg = stim_q[i].cfg;
      end
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc == c + 1) begin
        e = exp_q.pop_front();
        chk(e);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s cyc=%0d never reached (run length %0d)", e.name, e.cyc, n);
    end
    rst = 1'b0; cfg_wr = 1'b0; cfg = '0;
    stim_q.delete();
  endtask
  task automatic do_reset();
    rs(0); rs(1);
    ex(2, 4'hF, Z, 0, 0, 0, "reset");
    run(2);
  endtask
  initial begin
    do_reset();
    // single sequence
    wr(0, A);
    for (int c = 1; c <= 4; c++) ex(c, 4'hE, Z, 1, 0, 0, "s1_break");
    ex(5, 4'hE, A, 1, 0, 0, "s1_apply");
    for (int c = 6; c <= 12; c++) ex(c, 4'hE, A, 1, 0, 0, "s1_settle");
    ex(13, 4'hF, A, 0, 1, 0, "s1_done");
    ex(14, 4'hF, A, 0, 0, 0, "s1_idle");
    run(14);
    // identical rewrite
    wr(0, A);
    ex(1, 4'hF, A, 0, 1, 0, "s2_same_done");
    ex(2, 4'hF, A, 0, 0, 0, "s2_after");
    run(2);
    // queued second write
    do_reset();
    wr(0, A); wr(6, B);
    ex(12, 4'hE, A, 1, 0, 0, "s3_last_settle");
    ex(13, 4'hF, Z, 1, 1, 0, "s3_done_chain");
    for (int c = 14; c <= 16; c++) ex(c, 4'hE, Z, 1, 0, 0, "s3_break2");
    ex(17, 4'hE, B, 1, 0, 0, "s3_apply_b");
    ex(24, 4'hE, B, 1, 0, 0, "s3_settle_b");
    ex(25, 4'hF, B, 0, 1, 0, "s3_done_b");
    run(26);
    // overwrite of pending
    do_reset();
    wr(0, A); wr(3, B); wr(7, C);
    ex(4, 4'h1, Z, 0, 0, 0, "s4_no_ovr");
    ex(8, 4'hF, A, 1, 0, 1, "s4_ovr");
    ex(9, 4'h1, Z, 0, 0, 0, "s4_ovr_once");
    ex(13, 4'hE, Z, 1, 1, 0, "s4_done_a");
    for (int c = 14; c <= 16; c++) ex(c, 4'h8, Z, 0, 0, 0, "s4_break_c");
    for (int c = 17; c <= 24; c++) ex(c, 4'hC, C, 1, 0, 0, "s4_apply_c");
    ex(25, 4'hF, C, 0, 1, 0, "s4_done_c");
    run(26);
    // reset mid-sequence
    do_reset();
    wr(0, A); wr(3, B); rs(6);
    ex(5, 4'hC, A, 1, 0, 0, "s5_applied");
    ex(7, 4'hF, Z, 0, 0, 0, "s5_reset");
    for (int c = 8; c <= 27; c++) ex(c, 4'hE, Z, 0, 0, 0, "s5_quiet");
    run(28);
    // write on final SETTLE cycle
    do_reset();
    wr(0, A); wr(12, B);
    ex(12, 4'hC, A, 1, 0, 0, "s6_last");
    ex(13, 4'hF, Z, 1, 1, 0, "s6_done_break");
    for (int c = 14; c <= 16; c++) ex(c, 4'hE, Z, 1, 0, 0, "s6_break");
    ex(17, 4'hC, B, 1, 0, 0, "s6_apply_b");
    ex(25, 4'hE, B, 0, 1, 0, "s6_done_b");
    run(26);
    // pending equal to just-applied config is discarded
    do_reset();
    wr(0, A); wr(2, A);
    ex(13, 4'hF, A, 0, 1, 0, "s7_done1");
    ex(14, 4'hF, A, 0, 1, 0, "s7_done2");
    ex(15, 4'hF, A, 0, 0, 0, "s7_quiet");
    run(16);
    // simultaneous overwrite on final cycle: newest write wins
    do_reset();
    wr(0, A); wr(5, B); wr(12, C);
    ex(13, 4'hF, Z, 1, 1, 1, "s8_ovr_fin");
    ex(17, 4'hC, C, 1, 0, 0, "s8_apply_c");
    run(18);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/analog_switch_seq.md
Name: analog_switch_seq

Overview:
- Break-before-make sequencer for the interface analog switch bank (pull-up/down, terminal resistance, loop P/N).
- Sits between the PCI register block and the combinational switch-select decoder.
- Accepts a configuration write, drives all switch selects to a safe state for a break interval, then applies the new settings.
- Holds busy through a settle interval, then reports completion.
- Queues one write that arrives while a sequence is in flight.

Parameters:
- BREAK_CYC, 16, cycles the safe state is held before applying the new config (>=1)
- SETTLE_CYC, 100, cycles after the new config is applied before completion (>=1)
- CNT_W, 16, width of the interval down-counter; must hold max(BREAK_CYC, SETTLE_CYC)-1

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, synchronous, active-high
- cfg_wr_i  input  1  one-cycle write strobe from PCI control
- pud_sel_i  input  4  requested pull-up/down selection
- tr_sel_i  input  3  requested terminal resistance selection
- lp_sel_i  input  4  requested loop selection
- pud_sel_o  output  4  applied pull-up/down selection to the switch decoder
- tr_sel_o  output  3  applied terminal resistance selection
- lp_sel_o  output  4  applied loop selection
- busy_o  output  1  sequence in progress (BREAK or SETTLE)
- done_o  output  1  one-cycle pulse: requested config applied and settled
- ovr_o  output  1  one-cycle pulse: a pending write was overwritten

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: all *_sel_o = 0 (safe state: all switches open, loops open on the P side), busy_o = 0, done_o = 0, ovr_o = 0, state = IDLE, pending empty, current-config register = 0.
- Outputs: all outputs are registered. The 11-bit config is the concatenation {pud, tr, lp}.
- States: IDLE, BREAK, SETTLE.

IDLE:
- cfg_wr_i with a config different from the current one: latch it as the target. Next cycle: *_sel_o = 0, state = BREAK, busy_o = 1, counter = BREAK_CYC-1.
- cfg_wr_i with a config equal to the current one: no sequence. done_o pulses the next cycle, busy_o stays 0, outputs are unchanged.

BREAK:
- Counter decrements each cycle.
- At counter = 0, the next cycle gives *_sel_o = target, state = SETTLE, counter = SETTLE_CYC-1.
- The safe state is therefore held for exactly BREAK_CYC cycles.

SETTLE:
- Counter decrements each cycle.
- At counter = 0, the next cycle gives done_o = 1 and current = target.
- If no write is pending: state = IDLE, busy_o = 0.
- If a write is pending: its config becomes the target, pending is cleared, and the FSM enters BREAK immediately. *_sel_o = 0, busy_o stays 1, and done_o still pulses for the finished sequence.
- A pending config equal to the just-applied one: it is discarded, the FSM goes to IDLE, and a second done_o pulses one cycle later.

Write while busy (BREAK or SETTLE):
- The input config is stored in a one-deep pending register.
- If pending is already full, it is overwritten and ovr_o pulses the next cycle.
- The in-flight target is never modified.

Simultaneous events:
- A write in the same cycle SETTLE completes: the write goes to pending first and is then consumed by the BREAK entry (treated as pending).
- If pending was already full in that cycle, the new write overwrites it, ovr_o pulses, and the new write is the one used.

Other rules:
- rst_i asserted mid-sequence: next cycle, all reset values apply. The pending write is lost and no done_o is generated.
- Latency from accepted write to applied config: BREAK_CYC+1 cycles.
- Latency from accepted write to done_o: BREAK_CYC+SETTLE_CYC+1 cycles.
- The counter never wraps. It is loaded only on state entry.

Test Plan (BREAK_CYC=4, SETTLE_CYC=8):
1. Reset, then write pud=4'hF, tr=3'h5, lp=4'hA at cycle 0 -> cycles 1-4: sel_o=0, busy=1; cycle 5: pud_sel_o=F, tr_sel_o=5, lp_sel_o=A; cycle 13: done_o=1, busy=0.
2. Re-write the identical config from scenario 1 while IDLE -> done_o=1 the next cycle, busy_o stays 0, sel_o unchanged.
3. Write A at cycle 0, write B (pud=1, tr=0, lp=3) at cycle 6 -> done_o at 13; cycles 13-16: sel_o=0; cycle 17: sel_o=B; done_o at 25.
4. During a sequence, write B at cycle 3 and C at cycle 7 -> ovr_o=1 at cycle 8; the following sequence applies C, and B is never driven.
5. Write at cycle 0, assert rst_i at cycle 6 -> cycle 7: all sel_o=0, busy_o=0; no done_o for the next 20 cycles.
6. Write exactly in the last SETTLE cycle (cycle 12) with pending empty -> done_o at 13 and BREAK begins at 13 with busy_o continuously 1.
